// File: rtl/vga_draw_pkg.sv
// Shared widths, default geometry and FSM encoding for the VGA draw scheduler.
package vga_draw_pkg;

    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 9;
    localparam int unsigned COLOR_W = 9;

    localparam int unsigned        H_RES_DEF    = 640;
    localparam int unsigned        V_RES_DEF    = 480;
    localparam logic [COLOR_W-1:0] BG_COLOR_DEF = 9'h000;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SERVE = 2'd2
    } state_e;

endpackage

// File: rtl/vga_draw_scheduler_rr_arbiter.sv
// Round-robin first-set search starting at ptr_i; purely combinational.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_c_o,
    output logic [IDX_W-1:0] idx_c_o,
    output logic             any_c_o
);

    logic [IDX_W-1:0] k;

    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        any_c_o = 1'b0;
        k       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = IDX_W'((32'(ptr_i) + i) % N);
            if (!any_c_o && req_i[k]) begin
                any_c_o    = 1'b1;
                idx_c_o    = k;
                gnt_c_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Shares the VGA pixel-write port between drawer clients, with a built-in
// full-screen clear sweep after reset and on request.
module vga_draw_scheduler
    import vga_draw_pkg::*;
#(
    parameter int unsigned        NUM_CLIENTS = 3,
    parameter int unsigned        H_RES       = H_RES_DEF,
    parameter int unsigned        V_RES       = V_RES_DEF,
    parameter logic [COLOR_W-1:0] BG_COLOR    = BG_COLOR_DEF,
    parameter int unsigned        MAX_GRANT   = 65536
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           clear_req,
    input  logic [NUM_CLIENTS-1:0]         client_req,
    input  logic [NUM_CLIENTS*X_W-1:0]     client_x,
    input  logic [NUM_CLIENTS*Y_W-1:0]     client_y,
    input  logic [NUM_CLIENTS*COLOR_W-1:0] client_color,
    input  logic [NUM_CLIENTS-1:0]         client_plot,
    input  logic [NUM_CLIENTS-1:0]         client_done,
    output logic [NUM_CLIENTS-1:0]         client_grant,
    output logic [X_W-1:0]                 vga_x,
    output logic [Y_W-1:0]                 vga_y,
    output logic [COLOR_W-1:0]             vga_color,
    output logic                           vga_plot,
    output logic                           busy,
    output logic                           err_timeout
);

    localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned CNT_W = (MAX_GRANT > 1) ? $clog2(MAX_GRANT) : 1;

    state_e                   state_q, state_d;
    logic [X_W-1:0]           cx_q, cx_d;
    logic [Y_W-1:0]           cy_q, cy_d;
    logic [NUM_CLIENTS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]         gidx_q, gidx_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]         gcnt_q, gcnt_d;
    logic                     clear_pending_q, clear_pending_d;
    logic [X_W-1:0]           vga_x_q, vga_x_d;
    logic [Y_W-1:0]           vga_y_q, vga_y_d;
    logic [COLOR_W-1:0]       vga_color_q, vga_color_d;
    logic                     vga_plot_q, vga_plot_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;

    logic [NUM_CLIENTS-1:0]   arb_gnt;
    logic [IDX_W-1:0]         arb_idx;
    logic                     arb_any;

    rr_arbiter #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (client_req),
        .ptr_i   (rr_ptr_q),
        .gnt_c_o (arb_gnt),
        .idx_c_o (arb_idx),
        .any_c_o (arb_any)
    );

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q         <= ST_CLEAR;
            cx_q            <= '0;
            cy_q            <= '0;
            grant_q         <= '0;
            gidx_q          <= '0;
            rr_ptr_q        <= '0;
            gcnt_q          <= '0;
            clear_pending_q <= 1'b0;
            vga_x_q         <= '0;
            vga_y_q         <= '0;
            vga_color_q     <= '0;
            vga_plot_q      <= 1'b0;
            busy_q          <= 1'b1;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            cx_q            <= cx_d;
            cy_q            <= cy_d;
            grant_q         <= grant_d;
            gidx_q          <= gidx_d;
            rr_ptr_q        <= rr_ptr_d;
            gcnt_q          <= gcnt_d;
            clear_pending_q <= clear_pending_d;
            vga_x_q         <= vga_x_d;
            vga_y_q         <= vga_y_d;
            vga_color_q     <= vga_color_d;
            vga_plot_q      <= vga_plot_d;
            busy_q          <= busy_d;
            err_q           <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state_q;
        cx_d            = cx_q;
        cy_d            = cy_q;
        grant_d         = grant_q;
        gidx_d          = gidx_q;
        rr_ptr_d        = rr_ptr_q;
        gcnt_d          = gcnt_q;
        clear_pending_d = clear_pending_q;
        vga_x_d         = vga_x_q;
        vga_y_d         = vga_y_q;
        vga_color_d     = vga_color_q;
        vga_plot_d      = 1'b0;
        err_d           = 1'b0;

        unique case (state_q)
            ST_CLEAR: begin
                vga_plot_d  = 1'b1;
                vga_x_d     = cx_q;
                vga_y_d     = cy_q;
                vga_color_d = BG_COLOR;
                grant_d     = '0;
                if (cx_q == X_W'(H_RES - 1)) begin
                    cx_d = '0;
                    if (cy_q == Y_W'(V_RES - 1)) begin
                        cy_d            = '0;
                        state_d         = ST_IDLE;
                        clear_pending_d = 1'b0;
                    end else begin
                        cy_d = cy_q + Y_W'(1);
                    end
                end else begin
                    cx_d = cx_q + X_W'(1);
                end
            end

            ST_IDLE: begin
                if (clear_pending_q || clear_req) begin
                    state_d = ST_CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (arb_any) begin
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    gcnt_d  = '0;
                    state_d = ST_SERVE;
                end
            end

            ST_SERVE: begin
                vga_x_d     = client_x[32'(gidx_q)*X_W +: X_W];
                vga_y_d     = client_y[32'(gidx_q)*Y_W +: Y_W];
                vga_color_d = client_color[32'(gidx_q)*COLOR_W +: COLOR_W];
                vga_plot_d  = client_plot[gidx_q];
                if (clear_req) begin
                    clear_pending_d = 1'b1;
                end
                // Done and timeout release identically; only timeout flags an error.
                if (client_done[gidx_q] || (gcnt_q == CNT_W'(MAX_GRANT - 1))) begin
                    err_d    = !client_done[gidx_q];
                    grant_d  = '0;
                    rr_ptr_d = (gidx_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : gidx_q + IDX_W'(1);
                    state_d  = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_CLEAR;
                cx_d    = '0;
                cy_d    = '0;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign client_grant = grant_q;
    assign vga_x        = vga_x_q;
    assign vga_y        = vga_y_q;
    assign vga_color    = vga_color_q;
    assign vga_plot     = vga_plot_q;
    assign busy         = busy_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Bench for vga_draw_scheduler: directed scenarios plus random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_vga_draw_scheduler;

    localparam int N    = 3;
    localparam int H    = 4;
    localparam int V    = 2;
    localparam int MAXG = 16;
    localparam int BG   = 9'h000;

    logic            clock = 1'b0;
    logic            resetn;
    logic            clear_req;
    logic [N-1:0]    client_req;
    logic [N*10-1:0] client_x;
    logic [N*9-1:0]  client_y;
    logic [N*9-1:0]  client_color;
    logic [N-1:0]    client_plot;
    logic [N-1:0]    client_done;
    logic [N-1:0]    client_grant;
    logic [9:0]      vga_x;
    logic [8:0]      vga_y;
    logic [8:0]      vga_color;
    logic            vga_plot;
    logic            busy;
    logic            err_timeout;

    always #5 clock = ~clock;

    vga_draw_scheduler #(
        .NUM_CLIENTS (N),
        .H_RES       (H),
        .V_RES       (V),
        .BG_COLOR    (9'(BG)),
        .MAX_GRANT   (MAXG)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .clear_req    (clear_req),
        .client_req   (client_req),
        .client_x     (client_x),
        .client_y     (client_y),
        .client_color (client_color),
        .client_plot  (client_plot),
        .client_done  (client_done),
        .client_grant (client_grant),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_color    (vga_color),
        .vga_plot     (vga_plot),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: pixels left in the sweep, current owner (-1 = none), cycles held.
    int m_left, m_owner, m_held, m_rr;
    bit m_pend;
    int e_grant, e_x, e_y, e_col;
    bit e_plot, e_busy, e_err;

    task automatic model_reset();
        m_left  = H * V;
        m_owner = -1;
        m_held  = 0;
        m_rr    = 0;
        m_pend  = 0;
        e_grant = 0; e_x = 0; e_y = 0; e_col = 0;
        e_plot  = 0; e_err = 0; e_busy = 1;
    endtask

    task automatic model_step();
        int p;
        e_err = 0;
        if (m_left > 0) begin
            p      = H * V - m_left;
            e_plot = 1; e_x = p % H; e_y = p / H; e_col = BG;
            e_grant = 0;
            m_left--;
            if (m_left == 0) m_pend = 0;
        end else if (m_owner < 0) begin
            e_plot = 0;
            if (m_pend || clear_req) begin
                m_left = H * V;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (m_owner < 0 && client_req[c]) begin
                        m_owner = c; m_held = 0; e_grant = 1 << c;
                    end
                end
            end
        end else begin
            e_x    = client_x[m_owner*10 +: 10];
            e_y    = client_y[m_owner*9 +: 9];
            e_col  = client_color[m_owner*9 +: 9];
            e_plot = client_plot[m_owner];
            if (clear_req) m_pend = 1;
            if (client_done[m_owner] || m_held == MAXG - 1) begin
                e_err   = !client_done[m_owner];
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
                e_grant = 0;
            end else begin
                m_held++;
            end
        end
        e_busy = (m_left > 0) || (m_owner >= 0);
    endtask

    task automatic check_outputs();
        check("grant", 32'(client_grant), 32'(e_grant));
        check("plot", 32'(vga_plot), 32'(e_plot));
        check("busy", 32'(busy), 32'(e_busy));
        check("err_timeout", 32'(err_timeout), 32'(e_err));
        if (e_plot) begin
            check("vga_x", 32'(vga_x), 32'(e_x));
            check("vga_y", 32'(vga_y), 32'(e_y));
            check("vga_color", 32'(vga_color), 32'(e_col));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic quiet_inputs();
        clear_req   = 0;
        client_req  = '0;
        client_plot = '0;
        client_done = '0;
    endtask

    task automatic rand_fields();
        client_x     = 30'($urandom);
        client_y     = 27'($urandom);
        client_color = 27'($urandom);
    endtask

    task automatic check_reset_values();
        check("rst_grant", 32'(client_grant), 0);
        check("rst_plot", 32'(vga_plot), 0);
        check("rst_x", 32'(vga_x), 0);
        check("rst_y", 32'(vga_y), 0);
        check("rst_color", 32'(vga_color), 0);
        check("rst_err", 32'(err_timeout), 0);
        check("rst_busy", 32'(busy), 1);
    endtask

    task automatic do_reset();
        resetn = 0;
        #2;
        check_reset_values();
        @(posedge clock);
        #1;
        check_reset_values();
        resetn = 1;
        model_reset();
    endtask

    int gseq[$];
    int plot_cnt;

    initial begin
        resetn = 1;
        quiet_inputs();
        rand_fields();
        #1;
        do_reset();

        // Post-reset clear sweep, then idle.
        plot_cnt = 0;
        for (int i = 0; i < H * V + 2; i++) begin
            step();
            if (vga_plot) plot_cnt++;
        end
        check("clear_plot_cycles", 32'(plot_cnt), 32'(H * V));
        check("busy_after_clear", 32'(busy), 0);

        // Client 1 alone: request, one pixel, done.
        client_req = 3'b010;
        step();
        check("c1_granted", 32'(client_grant), 32'b010);
        client_x[19:10] = 10'd5; client_y[17:9] = 9'd7; client_color[17:9] = 9'h1FF;
        client_plot = 3'b010; client_done = 3'b010;
        step();
        check("c1_pixel", {vga_plot, vga_x, vga_y, vga_color}, {1'b1, 10'd5, 9'd7, 9'h1FF});
        check("c1_released", 32'(client_grant), 0);
        quiet_inputs();
        step();
        step();

        // All requests held, each done three cycles after its grant; client 0 always plots.
        do_reset();
        for (int i = 0; i < H * V; i++) step();
        gseq.delete();
        for (int i = 0; i < 30; i++) begin
            rand_fields();
            client_req  = 3'b111;
            client_plot = 3'(3'b001 | 3'($urandom));
            client_done = (m_owner >= 0 && m_held == 2) ? 3'(1 << m_owner) : 3'b000;
            step();
            if (client_grant != 0 && (gseq.size() == 0 || e_grant != 0 && m_held == 0))
                gseq.push_back(int'(client_grant));
            if (client_grant == 3'b010)
                client_plot = 3'b001;
        end
        check("rr_order_len_ok", 32'(gseq.size() >= 4), 1);
        if (gseq.size() >= 4) begin
            check("rr_order0", 32'(gseq[0]), 1);
            check("rr_order1", 32'(gseq[1]), 2);
            check("rr_order2", 32'(gseq[2]), 4);
            check("rr_order3", 32'(gseq[3]), 1);
        end
        quiet_inputs();
        for (int i = 0; i < 4; i++) step();

        // Two clear pulses during client 2 service collapse into one sweep.
        client_req = 3'b100;
        for (int i = 0; i < 20 && m_owner != 2; i++) step();
        check("c2_owner", 32'(client_grant), 32'b100);
        client_req = 3'b000;
        clear_req = 1; step();
        clear_req = 0; step();
        clear_req = 1; step();
        clear_req = 0; client_done = 3'b100; step();
        client_done = 3'b000; client_req = 3'b001;
        plot_cnt = 0;
        for (int i = 0; i < 3 * H * V; i++) begin
            step();
            if (vga_plot) plot_cnt++;
        end
        check("single_clear_plots", 32'(plot_cnt), 32'(H * V));
        check("c0_after_clear", 32'(client_grant), 32'b001);

        // Client 0 never signals done: revoked by timeout.
        quiet_inputs();
        client_req = 3'b011;
        for (int i = 0; i < MAXG + 4; i++) step();
        quiet_inputs();
        step();
        step();

        // Random traffic with one asynchronous reset landing mid-service.
        begin
            bit did_rst;
            did_rst = 0;
            for (int i = 0; i < 1500; i++) begin
                rand_fields();
                client_req  = 3'($urandom);
                client_plot = 3'($urandom);
                client_done = '0;
                for (int c = 0; c < N; c++)
                    if ($urandom_range(5) == 0) client_done[c] = 1'b1;
                clear_req = ($urandom_range(59) == 0);
                if (!did_rst && i >= 700 && m_owner >= 0) begin
                    did_rst = 1;
                    do_reset();
                end else begin
                    step();
                end
            end
            check("mid_reset_taken", 32'(did_rst), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
